// File: rtl/ip_amba_apb_master_arbiter_if.sv
// APB bus bundle between the arbiter (master side) and the shared APB slave.
`timescale 1ns/1ps

interface ip_amba_apb_master_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic              pready;
  logic              pslverr;
  logic [DATA_W-1:0] prdata;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  pready, pslverr, prdata
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output pready, pslverr, prdata
  );
endinterface

// File: rtl/ip_amba_apb_master_arbiter.sv
// Round-robin arbiter plus APB master sequencer. One command is accepted at a
// time from N_REQ requesters, sequenced through APB SETUP/ACCESS, and the
// response (or a timeout abort) is returned to the requester that was granted.
`timescale 1ns/1ps

module ip_amba_apb_master_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                      ip_amba_apb_master_arbiter_clock,
  input  logic                      ip_amba_apb_master_arbiter_reset,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ-1:0]          req_write,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_wdata,
  output logic [N_REQ-1:0]          req_ready,
  output logic [N_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_slverr,
  output logic                      timeout_err,
  ip_amba_apb_master_arbiter_if.master apb
);

  localparam int PTR_W  = $clog2(N_REQ);
  localparam int CAND_W = PTR_W + 1;
  // A zero TIMEOUT still gets a 1-bit counter so the logic stays well formed.
  localparam int CNT_W  = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t            state_q;
  logic [PTR_W-1:0]  rr_ptr;
  logic [CNT_W-1:0]  wait_cnt;
  logic              psel_q;
  logic              penable_q;
  logic              pwrite_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;

  logic              grant_found;
  logic [PTR_W-1:0]  grant_idx;
  logic [CAND_W-1:0] cand;

  assign apb.psel    = psel_q;
  assign apb.penable = penable_q;
  assign apb.pwrite  = pwrite_q;
  assign apb.paddr   = paddr_q;
  assign apb.pwdata  = pwdata_q;

  // Round-robin search: first valid requester above the last grant, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = {1'b0, rr_ptr} + CAND_W'(k);
      if (cand >= CAND_W'(N_REQ)) begin
        cand = cand - CAND_W'(N_REQ);
      end
      if (!grant_found && req_valid[cand[PTR_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[PTR_W-1:0];
      end
    end
  end

  // Acceptance pulse goes only to the winner, and only while the bus is idle.
  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && grant_found) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // Transfer sequencer: grant/latch, SETUP, ACCESS with wait-state timeout.
  always_ff @(posedge ip_amba_apb_master_arbiter_clock) begin
    if (ip_amba_apb_master_arbiter_reset) begin
      state_q     <= IDLE;
      rr_ptr      <= PTR_W'(N_REQ - 1);
      wait_cnt    <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid   <= '0;
      rsp_rdata   <= '0;
      rsp_slverr  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      rsp_valid   <= '0;
      timeout_err <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_found) begin
            paddr_q  <= req_addr[grant_idx*ADDR_W +: ADDR_W];
            pwdata_q <= req_wdata[grant_idx*DATA_W +: DATA_W];
            pwrite_q <= req_write[grant_idx];
            psel_q   <= 1'b1;
            rr_ptr   <= grant_idx;
            state_q  <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          wait_cnt  <= '0;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          if (apb.pready) begin
            rsp_valid[rr_ptr] <= 1'b1;
            rsp_rdata         <= pwrite_q ? '0 : apb.prdata;
            rsp_slverr        <= apb.pslverr;
            psel_q            <= 1'b0;
            penable_q         <= 1'b0;
            state_q           <= IDLE;
          end else if (TIMEOUT != 0 && wait_cnt == CNT_LAST) begin
            rsp_valid[rr_ptr] <= 1'b1;
            rsp_rdata         <= '0;
            rsp_slverr        <= 1'b1;
            timeout_err       <= 1'b1;
            psel_q            <= 1'b0;
            penable_q         <= 1'b0;
            state_q           <= IDLE;
          end else if (wait_cnt != CNT_MAX) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ip_amba_apb_master_arbiter.sv
// Scoreboard bench for the APB master arbiter: expected grants and responses
// are queued by the stimulus, and monitors pop/compare when the DUT presents them.
`timescale 1ns/1ps

module tb_ip_amba_apb_master_arbiter;

  typedef struct packed {
    logic [3:0]  vld;
    logic [31:0] rdata;
    logic        slverr;
    logic        tmo;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  // Main DUT (TIMEOUT=16)
  logic [3:0]   req_valid = '0, req_write = '0;
  logic [127:0] req_addr = '0, req_wdata = '0;
  logic [3:0]   req_ready, rsp_valid;
  logic [31:0]  rsp_rdata;
  logic         rsp_slverr, timeout_err;

  // Second DUT (TIMEOUT=4) for the abort path
  logic [3:0]   req_valid1 = '0, req_write1 = '0;
  logic [127:0] req_addr1 = '0, req_wdata1 = '0;
  logic [3:0]   req_ready1, rsp_valid1;
  logic [31:0]  rsp_rdata1;
  logic         rsp_slverr1, timeout_err1;

  exp_t       exp_q[$];
  exp_t       exp_q1[$];
  logic [3:0] exp_gnt[$];

  ip_amba_apb_master_arbiter_if #(.ADDR_W(32), .DATA_W(32)) apb0 ();
  ip_amba_apb_master_arbiter_if #(.ADDR_W(32), .DATA_W(32)) apb1 ();

  ip_amba_apb_master_arbiter #(.N_REQ(4), .ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut0 (
    .ip_amba_apb_master_arbiter_clock (clk),
    .ip_amba_apb_master_arbiter_reset (rst),
    .req_valid   (req_valid),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_slverr  (rsp_slverr),
    .timeout_err (timeout_err),
    .apb         (apb0.master)
  );

  ip_amba_apb_master_arbiter #(.N_REQ(4), .ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut1 (
    .ip_amba_apb_master_arbiter_clock (clk),
    .ip_amba_apb_master_arbiter_reset (rst),
    .req_valid   (req_valid1),
    .req_write   (req_write1),
    .req_addr    (req_addr1),
    .req_wdata   (req_wdata1),
    .req_ready   (req_ready1),
    .rsp_valid   (rsp_valid1),
    .rsp_rdata   (rsp_rdata1),
    .rsp_slverr  (rsp_slverr1),
    .timeout_err (timeout_err1),
    .apb         (apb1.master)
  );

  // 10 ns clock and a cycle counter for latency measurements
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [95:0] actual, input logic [95:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic expectRsp(input logic [3:0] vld, input logic [31:0] rdata, input logic slverr);
    exp_t e;
    e.vld = vld; e.rdata = rdata; e.slverr = slverr; e.tmo = 1'b0;
    exp_q.push_back(e);
  endtask

  // Drives one request (caller sits just after a rising edge) and holds it until accepted.
  task automatic applyStimulus(input int idx, input logic wr, input logic [31:0] addr,
                               input logic [31:0] data, output int acc_cyc);
    int n = 0;
    req_write[idx] = wr;
    req_addr[idx*32 +: 32] = addr;
    req_wdata[idx*32 +: 32] = data;
    req_valid[idx] = 1'b1;
    @(negedge clk);
    while (!req_ready[idx] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[idx]) begin
      checks++; errors++;
      $display("[TB] FAIL accept_wait requester=%0d actual=no_ready required=ready", idx);
    end
    acc_cyc = cyc;
    @(posedge clk); #1;
    req_valid[idx] = 1'b0;
  endtask

  // Holds a set of requesters valid and checks that grants land 3 cycles apart.
  task automatic runContention(input logic [3:0] mask, input int ngrants, input logic drop_each);
    int last = -1;
    int n;
    logic [3:0] g;
    req_valid = mask;
    for (int i = 0; i < ngrants; i++) begin
      n = 0;
      @(negedge clk);
      while (req_ready == 4'b0 && n < 30) begin
        @(negedge clk);
        n++;
      end
      if (req_ready == 4'b0) begin
        checks++; errors++;
        $display("[TB] FAIL grant_wait actual=no_grant required=grant %0d", i);
        req_valid = '0;
        return;
      end
      if (last >= 0) checkOutput("grant_spacing", 96'(cyc - last), 96'd3);
      last = cyc;
      g = req_ready;
      @(posedge clk); #1;
      if (drop_each) req_valid = req_valid & ~g;
    end
    req_valid = '0;
  endtask

  task automatic waitDrain();
    int n = 0;
    while ((exp_q.size() != 0 || exp_q1.size() != 0 || exp_gnt.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || exp_q1.size() != 0 || exp_gnt.size() != 0) begin
      checks++; errors++;
      $display("[TB] FAIL drain actual=%0d/%0d/%0d pending required=0",
               exp_q.size(), exp_q1.size(), exp_gnt.size());
      exp_q.delete(); exp_q1.delete(); exp_gnt.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Grant monitor: every acceptance pulse must match the next expected winner
  always @(negedge clk) begin
    if (!rst && req_ready != 4'b0) begin
      if (exp_gnt.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL unexpected_grant actual=%b required=none", req_ready);
      end else begin
        checkOutput("grant", 96'(req_ready), 96'(exp_gnt.pop_front()));
      end
    end
  end

  // Response monitor for the main DUT
  always @(negedge clk) begin
    exp_t e;
    if (!rst && rsp_valid != 4'b0) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL unexpected_rsp actual=%b required=none", rsp_valid);
      end else begin
        e = exp_q.pop_front();
        checkOutput("rsp_valid", 96'(rsp_valid), 96'(e.vld));
        checkOutput("rsp_rdata", 96'(rsp_rdata), 96'(e.rdata));
        checkOutput("rsp_slverr", 96'(rsp_slverr), 96'(e.slverr));
        checkOutput("timeout_err", 96'(timeout_err), 96'(e.tmo));
      end
    end
  end

  // Response monitor for the short-timeout DUT
  always @(negedge clk) begin
    exp_t e;
    if (!rst && rsp_valid1 != 4'b0) begin
      if (exp_q1.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL unexpected_rsp1 actual=%b required=none", rsp_valid1);
      end else begin
        e = exp_q1.pop_front();
        checkOutput("rsp_valid1", 96'(rsp_valid1), 96'(e.vld));
        checkOutput("rsp_rdata1", 96'(rsp_rdata1), 96'(e.rdata));
        checkOutput("rsp_slverr1", 96'(rsp_slverr1), 96'(e.slverr));
        checkOutput("timeout_err1", 96'(timeout_err1), 96'(e.tmo));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   acc;
    exp_t e;
    apb0.pready = 1'b1; apb0.pslverr = 1'b0; apb0.prdata = '0;
    apb1.pready = 1'b0; apb1.pslverr = 1'b0; apb1.prdata = 32'hFFFF_FFFF;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    $display("[TB] reset state");
    checkOutput("reset_apb", {apb0.psel, apb0.penable, apb0.pwrite, apb0.paddr, apb0.pwdata}, 96'd0);
    checkOutput("reset_rsp", {rsp_valid, rsp_rdata, rsp_slverr, timeout_err}, 96'd0);
    checkOutput("reset_apb1", {apb1.psel, apb1.penable, rsp_valid1, timeout_err1}, 96'd0);
    @(posedge clk); #1;

    $display("[TB] single read, zero wait");
    apb0.prdata = 32'hDEAD_BEEF;
    exp_gnt.push_back(4'b0100);
    expectRsp(4'b0100, 32'hDEAD_BEEF, 1'b0);
    applyStimulus(2, 1'b0, 32'h0000_0010, 32'h0, acc);
    @(negedge clk);
    checkOutput("t1_setup", {apb0.psel, apb0.penable}, 96'b10);
    @(negedge clk);
    checkOutput("t1_access", {apb0.psel, apb0.penable, apb0.pwrite, apb0.paddr}, {3'b110, 32'h10});
    @(negedge clk);
    checkOutput("t1_rsp_cycle", {rsp_valid, apb0.psel}, {4'b0100, 1'b0});
    checkOutput("t1_latency", 96'(cyc - acc), 96'd3);
    waitDrain();

    $display("[TB] round-robin contention");
    doReset();
    apb0.prdata = 32'h7777_7777;
    req_write = 4'hF;
    for (int i = 0; i < 4; i++) begin
      req_addr[i*32 +: 32]  = 32'(i) * 32'h100;
      req_wdata[i*32 +: 32] = 32'h1111_1111 * 32'(i + 1);
    end
    for (int i = 0; i < 5; i++) begin
      exp_gnt.push_back(4'b0001 << (i % 4));
      expectRsp(4'b0001 << (i % 4), 32'h0, 1'b0);
    end
    runContention(4'hF, 5, 1'b0);
    waitDrain();

    $display("[TB] wait states");
    apb0.pready = 1'b0;
    exp_gnt.push_back(4'b0010);
    expectRsp(4'b0010, 32'h0, 1'b0);
    applyStimulus(1, 1'b1, 32'h0000_0004, 32'hA5A5_0001, acc);
    @(negedge clk);
    checkOutput("t3_setup", {apb0.psel, apb0.penable}, 96'b10);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      apb0.pready = (k == 5);
      @(negedge clk);
      checkOutput("t3_access_stable",
                  {apb0.psel, apb0.penable, apb0.pwrite, apb0.paddr, apb0.pwdata, rsp_valid},
                  {3'b111, 32'h4, 32'hA5A5_0001, 4'b0000});
    end
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("t3_rsp_after_pready", {rsp_valid, apb0.psel}, {4'b0010, 1'b0});
    apb0.pready = 1'b1;
    waitDrain();

    $display("[TB] timeout abort");
    e.vld = 4'b0010; e.rdata = 32'h0; e.slverr = 1'b1; e.tmo = 1'b1;
    exp_q1.push_back(e);
    req_write1[1] = 1'b0;
    req_addr1[63:32] = 32'h0000_0020;
    req_valid1[1] = 1'b1;
    @(negedge clk);
    checkOutput("t4_grant", 96'(req_ready1), 96'b0010);
    @(posedge clk); #1;
    req_valid1 = '0;
    @(negedge clk);
    checkOutput("t4_setup", {apb1.psel, apb1.penable}, 96'b10);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("t4_access", {apb1.psel, apb1.penable, rsp_valid1}, {2'b11, 4'b0000});
    end
    @(negedge clk);
    checkOutput("t4_abort", {apb1.psel, apb1.penable, rsp_valid1, timeout_err1}, {2'b00, 4'b0010, 1'b1});
    @(negedge clk);
    checkOutput("t4_pulse_end", {rsp_valid1, timeout_err1}, 96'd0);
    waitDrain();

    $display("[TB] slave error");
    apb0.pslverr = 1'b1;
    apb0.prdata  = 32'h0000_1234;
    exp_gnt.push_back(4'b1000);
    expectRsp(4'b1000, 32'h0000_1234, 1'b1);
    applyStimulus(3, 1'b0, 32'h0000_0030, 32'h0, acc);
    repeat (4) @(negedge clk);
    checkOutput("t5_hold", {rsp_valid, rsp_rdata, rsp_slverr}, {4'b0000, 32'h1234, 1'b1});
    apb0.pslverr = 1'b0;
    waitDrain();

    $display("[TB] reset mid-access");
    apb0.pready = 1'b0;
    exp_gnt.push_back(4'b0100);
    applyStimulus(2, 1'b1, 32'h0000_0060, 32'h6666_6666, acc);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("t6_in_access", {apb0.psel, apb0.penable}, 96'b11);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("t6_after_reset", {apb0.psel, apb0.penable, rsp_valid}, 96'd0);
    @(posedge clk); #1;
    apb0.pready = 1'b1;
    apb0.prdata = 32'hCAFE_0000;
    req_write[0] = 1'b0; req_addr[31:0]   = 32'h70;
    req_write[1] = 1'b0; req_addr[63:32]  = 32'h74;
    req_write[3] = 1'b0; req_addr[127:96] = 32'h7C;
    exp_gnt.push_back(4'b0001); expectRsp(4'b0001, 32'hCAFE_0000, 1'b0);
    exp_gnt.push_back(4'b0010); expectRsp(4'b0010, 32'hCAFE_0000, 1'b0);
    exp_gnt.push_back(4'b1000); expectRsp(4'b1000, 32'hCAFE_0000, 1'b0);
    runContention(4'b1011, 3, 1'b1);
    waitDrain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
